// File: rtl/avalon_word_master.sv
// rtl/avalon_word_master.sv - Avalon-MM word-burst master (single-word reads/writes to on-chip RAM)
module avalon_word_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]        issue_q, issue_d;
    logic [LEN_W-1:0]        ret_q, ret_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [DATA_W-1:0]       rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_accept;
    logic                    capture;

    // The tail of the valid pipe marks the cycle in which the slave drives readdata.
    assign capture = pipe_q[READ_LATENCY-1];

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        issue_d        = issue_q;
        ret_d          = ret_q;
        cmd_ready      = 1'b0;
        wr_ready       = 1'b0;
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        rd_accept      = 1'b0;

        if (capture) begin
            ret_d = ret_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    issue_d = cmd_len;
                    ret_d   = cmd_write ? '0 : cmd_len;
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                avm_chipselect = wr_valid;
                avm_write      = wr_valid;
                wr_ready       = wr_valid & ~avm_waitrequest;
                if (wr_ready) begin
                    addr_d  = addr_q + 1'b1;
                    issue_d = issue_q - 1'b1;
                    if (issue_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                avm_chipselect = (issue_q != '0);
                rd_accept      = avm_chipselect & ~avm_waitrequest;
                if (rd_accept) begin
                    addr_d  = addr_q + 1'b1;
                    issue_d = issue_q - 1'b1;
                    if (issue_q == LEN_W'(1)) begin
                        state_d = (ret_d == '0) ? S_DONE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Registered count: done lands the cycle after the last rd_valid.
                if (ret_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pipe_d = '0;
        pipe_d[0] = rd_accept;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        rd_data_d  = capture ? avm_readdata : rd_data_q;
        rd_valid_d = capture;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            issue_q    <= '0;
            ret_q      <= '0;
            pipe_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            ret_q      <= ret_d;
            pipe_q     <= pipe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign avm_read       = avm_chipselect & ~avm_write;
    assign avm_address    = addr_q;
    assign avm_writedata  = wr_data;
    assign avm_byteenable = '1;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_avalon_word_master.sv
// tb/tb_avalon_word_master.sv - directed scoreboard bench for avalon_word_master with a latency-1 RAM model
module tb_avalon_word_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_addr;
    logic [2:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_exp[$];
    logic [31:0] rd_exp[$];
    logic [31:0] mem[4];
    logic [31:0] model_mem[4];

    avalon_word_master dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .busy            (busy),
        .done            (done),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: one-cycle registered read, write on select.
    always @(posedge clk) begin
        if (avm_chipselect && !avm_waitrequest) begin
            if (avm_write) mem[avm_address] <= avm_writedata;
            else           avm_readdata     <= mem[avm_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (reset_n === 1'b1) begin
            if (avm_chipselect && avm_write && !avm_waitrequest) begin
                if (wr_exp.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wr_exp.pop_front();
                    check("wr_addr", {30'd0, avm_address}, {30'd0, e.a});
                    check("wr_data", avm_writedata, e.d);
                end
            end
            if (rd_valid) begin
                if (rd_exp.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else                    check("rd_data", rd_data, rd_exp.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic wr, input logic [1:0] a, input logic [2:0] n);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = n;
        @(negedge clk);
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [1:0] a, input int n, input int stall_word,
                               input int stall_n, input logic [31:0] base);
        int stalls;
        int low_cnt;
        int guard;
        logic acc;
        logic [1:0] wa;
        start_cmd(1'b1, a, n[2:0]);
        for (int i = 0; i < n; i++) begin
            wa       = a + i[1:0];
            wr_data  = base + i;
            wr_valid = 1'b1;
            wr_exp.push_back('{a: wa, d: base + i});
            model_mem[wa] = base + i;
            stalls  = (i == stall_word) ? stall_n : 0;
            low_cnt = 0;
            guard   = 0;
            acc     = 1'b0;
            while (!acc && guard < 20) begin
                avm_waitrequest = (stalls > 0);
                @(negedge clk);
                if (stalls > 0) begin
                    if (wr_ready === 1'b0) low_cnt++;
                    check("stall_addr", {30'd0, avm_address}, {30'd0, wa});
                    check("stall_wdata", avm_writedata, base + i);
                    check("stall_strobe", {31'd0, avm_write}, 32'd1);
                end
                acc = wr_ready;
                tick();
                if (stalls > 0) stalls--;
                guard++;
            end
            check("wr_accepted", {31'd0, acc}, 32'd1);
            if (i == stall_word) check("stall_wr_ready_low", low_cnt, stall_n);
        end
        wr_valid        = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        check("wr_done_pulse", {31'd0, done}, 32'd1);
        check("wr_done_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        @(negedge clk);
        check("wr_done_clear", {31'd0, done}, 32'd0);
        check("wr_idle", {31'd0, busy}, 32'd0);
        tick();
    endtask

    task automatic read_burst(input logic [1:0] a, input int n);
        int acc_cnt, rv, cyc, first_acc, first_rv, last_rv, done_cyc;
        for (int i = 0; i < n; i++) rd_exp.push_back(model_mem[a + i[1:0]]);
        start_cmd(1'b0, a, n[2:0]);
        acc_cnt = 0; rv = 0; cyc = 0;
        first_acc = -1; first_rv = -1; last_rv = -1; done_cyc = -1;
        while (done_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            check("rd_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
            if (avm_read && !avm_waitrequest) begin
                check("rd_addr", {30'd0, avm_address}, (a + acc_cnt) & 3);
                if (first_acc < 0) first_acc = cyc;
                acc_cnt++;
            end
            if (rd_valid) begin
                if (first_rv < 0) first_rv = cyc;
                last_rv = cyc;
                rv++;
            end
            if (done) done_cyc = cyc;
            tick();
            cyc++;
        end
        check("rd_done_seen", {31'd0, done_cyc >= 0}, 32'd1);
        check("rd_accept_count", acc_cnt, n);
        check("rd_valid_count", rv, n);
        check("rd_first_latency", first_rv - first_acc, 32'd2);
        check("rd_back_to_back", last_rv - first_rv, n - 1);
        check("rd_done_after_last", done_cyc - last_rv, 32'd1);
        @(negedge clk);
        check("rd_done_clear", {31'd0, done}, 32'd0);
        check("rd_idle", {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        reset_n         = 1'b0;
        cmd_valid       = 1'b0;
        cmd_write       = 1'b0;
        cmd_addr        = 2'd0;
        cmd_len         = 3'd0;
        wr_data         = 32'd0;
        wr_valid        = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem[i]       = 32'd0;
            model_mem[i] = 32'd0;
        end

        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_strobes", {29'd0, avm_chipselect, avm_write, avm_read}, 32'd0);
        check("rst_byteenable", {28'd0, avm_byteenable}, 32'hF);
        tick();
        reset_n = 1'b1;
        tick();

        write_burst(2'd0, 4, -1, 0, 32'hA0);
        for (int i = 0; i < 4; i++) check("mem_after_write", mem[i], 32'hA0 + i);

        read_burst(2'd0, 4);
        read_burst(2'd3, 2);

        write_burst(2'd3, 3, 1, 3, 32'hB0);
        check("mem_wrap3", mem[3], 32'hB0);
        check("mem_wrap0", mem[0], 32'hB1);
        check("mem_wrap1", mem[1], 32'hB2);
        check("mem_untouched2", mem[2], 32'hA2);

        start_cmd(1'b1, 2'd2, 3'd0);
        @(negedge clk);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_no_strobe", {31'd0, avm_chipselect}, 32'd0);
        tick();
        @(negedge clk);
        check("len0_done_clear", {31'd0, done}, 32'd0);
        check("len0_no_strobe2", {31'd0, avm_chipselect}, 32'd0);
        check("len0_idle", {31'd0, cmd_ready}, 32'd1);
        tick();

        start_cmd(1'b0, 2'd0, 3'd4);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
        check("abort_strobes", {29'd0, avm_chipselect, avm_write, avm_read}, 32'd0);
        check("abort_addr", {30'd0, avm_address}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_abort_rd_valid", {31'd0, rd_valid}, 32'd0);
            check("post_abort_done", {31'd0, done}, 32'd0);
            tick();
        end

        read_burst(2'd0, 4);

        check("wr_queue_empty", wr_exp.size(), 32'd0);
        check("rd_queue_empty", rd_exp.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
